// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and FSM state type for the UART receive front end
package uart_pkg;
   // 8 MHz / 115200 baud = 69.44 cycles per bit, truncated
   localparam int CLKS_PER_BIT = 69;
   localparam int DATA_BITS = 8;
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
endpackage

// File: rtl/rx_sync_filter.sv
// rx_sync_filter: 2-FF synchroniser plus 3-tap majority filter for the RX line
// Ports: clk_8mhz/rst_n clock and async active-low reset; rx_wire raw pin;
//        newest = most recent synchronised tap; filt = majority of the 3 taps.
module rx_sync_filter (
   input  logic clk_8mhz,
   input  logic rst_n,
   input  logic rx_wire,
   output logic newest,
   output logic filt
);
   logic [1:0] sync;
   logic [2:0] taps;
   // everything resets to the idle-high line level
   always_ff @(posedge clk_8mhz or negedge rst_n) begin
      if (!rst_n) begin
         sync <= '1;
         taps <= '1;
      end else begin
         sync <= {sync[0], rx_wire};
         taps <= {taps[1:0], sync[1]};
      end
   end
   assign newest = taps[0];
   assign filt = (taps[0] & taps[1]) | (taps[0] & taps[2]) | (taps[1] & taps[2]);
endmodule

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: validates start bits and samples UART data bits at mid-bit
// Ports: clk_8mhz/rst_n clock and async active-low reset; rx_wire raw RX pin;
//        out_bit sampled bit (valid with valid_now); valid_now one strobe per
//        data bit; byte_start pulse per validated start; frame_err pulse on low stop.
module uart_rx_sampler #(
   parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT
) (
   input  logic clk_8mhz,
   input  logic rst_n,
   input  logic rx_wire,
   output logic out_bit,
   output logic valid_now,
   output logic byte_start,
   output logic frame_err
);
   import uart_pkg::*;
   localparam int HALF_BIT = CLKS_PER_BIT / 2;
   localparam logic [6:0] BIT_LAST = 7'(CLKS_PER_BIT - 1);
   localparam logic [6:0] HALF_LAST = 7'(HALF_BIT - 1);
   localparam logic [2:0] IDX_LAST = 3'(DATA_BITS - 1);
   state_t state;
   logic [6:0] cnt;
   logic [2:0] bit_idx;
   logic newest, filt;
   rx_sync_filter u_filter (
      .clk_8mhz(clk_8mhz),
      .rst_n(rst_n),
      .rx_wire(rx_wire),
      .newest(newest),
      .filt(filt)
   );
   always_ff @(posedge clk_8mhz or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         bit_idx <= '0;
         out_bit <= 1'b0;
         valid_now <= 1'b0;
         byte_start <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         valid_now <= 1'b0;
         byte_start <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               // start detection reacts to the newest tap for minimum latency
               cnt <= '0;
               if (!newest) state <= START;
            end
            START: begin
               cnt <= cnt == HALF_LAST ? 7'd0 : cnt + 7'd1;
               if (cnt == HALF_LAST) begin
                  if (filt) state <= IDLE;
                  else begin
                     byte_start <= 1'b1;
                     bit_idx <= '0;
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               cnt <= cnt == BIT_LAST ? 7'd0 : cnt + 7'd1;
               if (cnt == BIT_LAST) begin
                  out_bit <= filt;
                  valid_now <= 1'b1;
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == IDX_LAST) state <= STOP;
               end
            end
            STOP: begin
               cnt <= cnt == BIT_LAST ? 7'd0 : cnt + 7'd1;
               // leaving at mid stop bit lets a back-to-back start edge be seen
               if (cnt == BIT_LAST) begin
                  if (filt) state <= IDLE;
                  else begin
                     frame_err <= 1'b1;
                     state <= BREAK;
                  end
               end
            end
            BREAK: begin
               cnt <= '0;
               if (filt) state <= IDLE;
            end
            default: begin
               cnt <= '0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
